// File: rtl/acl_pkg.sv
// Shared constants, FSM state type and axis conversion for the ADXL362 reader.
package acl_pkg;

    // ADXL362 command opcodes
    localparam logic [7:0] OP_WRITE      = 8'h0A;
    localparam logic [7:0] OP_READ       = 8'h0B;

    // ADXL362 register addresses and values
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA     = 8'h08;
    localparam logic [7:0] VAL_MEASURE   = 8'h02;
    localparam logic [7:0] DUMMY_BYTE    = 8'h00;

    // Frame lengths in bytes
    localparam int CFG_BYTES  = 3;
    localparam int READ_BYTES = 5;

    // acl_data field positions
    localparam int X_HI = 14;
    localparam int X_LO = 10;
    localparam int Y_HI = 9;
    localparam int Y_LO = 5;
    localparam int Z_HI = 4;
    localparam int Z_LO = 0;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_CFG,
        ST_GAP,
        ST_WAIT,
        ST_READ,
        ST_LATCH
    } state_t;

    // Sign + 4-bit magnitude. The absolute value is kept 8 bits wide so that
    // -128 yields 128 and saturates to 15 instead of wrapping to 0.
    function automatic logic [4:0] axis_conv(input logic [7:0] v);
        logic [7:0] abs_v;
        logic [3:0] mag;
        abs_v = v[7] ? (~v + 8'd1) : v;
        mag   = abs_v[7] ? 4'hF : abs_v[6:3];
        return {v[7], mag};
    endfunction

    // Transmit byte for a given frame type and byte position
    function automatic logic [7:0] frame_byte(input logic is_read, input logic [2:0] idx);
        logic [7:0] b;
        b = DUMMY_BYTE;
        if (is_read) begin
            case (idx)
                3'd0:    b = OP_READ;
                3'd1:    b = REG_XDATA;
                default: b = DUMMY_BYTE;
            endcase
        end else begin
            case (idx)
                3'd0:    b = OP_WRITE;
                3'd1:    b = REG_POWER_CTL;
                3'd2:    b = VAL_MEASURE;
                default: b = DUMMY_BYTE;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One-byte SPI mode-0 shifter. A start pulse loads tx_byte; MSB appears on
// mosi the next cycle. sclk toggles every CLK_DIV cycles starting low.
// done is a combinational strobe in the cycle whose clock edge produces the
// eighth falling sclk edge; a start in that same cycle chains the next byte
// with no idle time, so the new MSB lands exactly on that falling edge.
module spi_byte_xfer #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          busy;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh;
    logic          tick;

    assign tick = busy && (div_cnt == '0);
    assign done = tick && sclk && (bit_cnt == 3'd7);
    assign mosi = tx_sh[7];

    // Half-period divider, sclk generation, shift-out on fall, sample on rise
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_byte <= '0;
            sclk    <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            div_cnt <= DIV_LAST;
            bit_cnt <= '0;
            tx_sh   <= tx_byte;
            sclk    <= 1'b0;
        end else if (done) begin
            busy    <= 1'b0;
            sclk    <= 1'b0;
            tx_sh   <= '0;
        end else if (tick) begin
            div_cnt <= DIV_LAST;
            sclk    <= ~sclk;
            if (!sclk) begin
                rx_byte <= {rx_byte[6:0], miso};
            end else begin
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else if (busy) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/acl_spi_reader.sv
// ADXL362 SPI reader: configures measurement mode after power-up, then
// burst-reads X/Y/Z on a fixed sample period and publishes a packed
// sign/magnitude word with a one-cycle valid strobe.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// STARTUP  | power-up delay before talking to the sensor
// CFG      | write POWER_CTL = measure (3 bytes), then tail before cs_n rise
// GAP      | cs_n held high for the minimum inter-frame gap
// WAIT     | idle until the sample timer expires (or an expiry is pending)
// READ     | burst read from XDATA (5 bytes), then tail before cs_n rise
// LATCH    | convert and publish acl_data, pulse data_valid
module acl_spi_reader
    import acl_pkg::*;
#(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 10_000_000,
    parameter int STARTUP_WAIT  = 1_000_000,
    parameter int CS_GAP        = 50
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [14:0] acl_data,
    output logic        data_valid
);

    localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_WAIT - 1);
    localparam logic [31:0] GAP_LAST     = 32'(CS_GAP - 1);
    localparam logic [31:0] TAIL_LAST    = 32'(CLK_DIV - 1);
    localparam logic [31:0] PERIOD_LAST  = 32'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]  CFG_LAST     = 3'(CFG_BYTES - 1);
    localparam logic [2:0]  READ_LAST    = 3'(READ_BYTES - 1);

    state_t      state, state_next;
    logic [31:0] phase_cnt;
    logic [31:0] sample_cnt;
    logic        timer_run;
    logic        pending;
    logic        expire;
    logic [2:0]  byte_idx;
    logic        tail;
    logic [7:0]  rx_x, rx_y, rx_z;

    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic [7:0]  xfer_rx;
    logic        xfer_done;
    logic        frame_start;
    logic        frame_end;
    logic        enter_tail;

    assign expire = timer_run && (sample_cnt == '0);

    spi_byte_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .start   (xfer_start),
        .tx_byte (xfer_tx),
        .rx_byte (xfer_rx),
        .done    (xfer_done),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    // Sequencer next-state, byte launch and frame boundary decode
    always_comb begin
        state_next  = state;
        xfer_start  = 1'b0;
        xfer_tx     = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        enter_tail  = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (phase_cnt == STARTUP_LAST) begin
                    state_next  = ST_CFG;
                    xfer_start  = 1'b1;
                    frame_start = 1'b1;
                    xfer_tx     = frame_byte(1'b0, 3'd0);
                end
            end
            ST_CFG: begin
                if (tail) begin
                    if (phase_cnt == TAIL_LAST) begin
                        state_next = ST_GAP;
                        frame_end  = 1'b1;
                    end
                end else if (xfer_done) begin
                    if (byte_idx != CFG_LAST) begin
                        xfer_start = 1'b1;
                        xfer_tx    = frame_byte(1'b0, byte_idx + 3'd1);
                    end else begin
                        enter_tail = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (phase_cnt == GAP_LAST) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (expire || pending) begin
                    state_next  = ST_READ;
                    xfer_start  = 1'b1;
                    frame_start = 1'b1;
                    xfer_tx     = frame_byte(1'b1, 3'd0);
                end
            end
            ST_READ: begin
                if (tail) begin
                    if (phase_cnt == TAIL_LAST) begin
                        state_next = ST_LATCH;
                        frame_end  = 1'b1;
                    end
                end else if (xfer_done) begin
                    if (byte_idx != READ_LAST) begin
                        xfer_start = 1'b1;
                        xfer_tx    = frame_byte(1'b1, byte_idx + 3'd1);
                    end else begin
                        enter_tail = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                state_next = ST_GAP;
            end
            default: begin
                state_next = ST_STARTUP;
            end
        endcase
    end

    // State register, phase counter, chip select and frame bookkeeping
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state     <= ST_STARTUP;
            phase_cnt <= '0;
            byte_idx  <= '0;
            tail      <= 1'b0;
            cs_n      <= 1'b1;
            rx_x      <= '0;
            rx_y      <= '0;
            rx_z      <= '0;
        end else begin
            state <= state_next;

            if ((state_next != state) || enter_tail) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 32'd1;
            end

            if (frame_start) begin
                cs_n     <= 1'b0;
                byte_idx <= '0;
                tail     <= 1'b0;
            end else begin
                if (frame_end) begin
                    cs_n <= 1'b1;
                end
                if (xfer_start) begin
                    byte_idx <= byte_idx + 3'd1;
                end
                if (enter_tail) begin
                    tail <= 1'b1;
                end
            end

            if ((state == ST_READ) && !tail && xfer_done) begin
                case (byte_idx)
                    3'd2:    rx_x <= xfer_rx;
                    3'd3:    rx_y <= xfer_rx;
                    3'd4:    rx_z <= xfer_rx;
                    default: ;
                endcase
            end
        end
    end

    // Sample timer: free-running from the end of the config write; an expiry
    // seen outside WAIT is remembered once so a slow frame never drops a sample
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sample_cnt <= '0;
            timer_run  <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if ((state == ST_CFG) && frame_end) begin
                timer_run  <= 1'b1;
                sample_cnt <= PERIOD_LAST;
            end else if (timer_run) begin
                sample_cnt <= (sample_cnt == '0) ? PERIOD_LAST : sample_cnt - 32'd1;
            end

            if (expire && (state != ST_WAIT)) begin
                pending <= 1'b1;
            end else if ((state == ST_WAIT) && (state_next == ST_READ)) begin
                pending <= 1'b0;
            end
        end
    end

    // Publish all three axes together with a single-cycle valid strobe
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            acl_data   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == ST_LATCH) begin
                acl_data[X_HI:X_LO] <= axis_conv(rx_x);
                acl_data[Y_HI:Y_LO] <= axis_conv(rx_y);
                acl_data[Z_HI:Z_LO] <= axis_conv(rx_z);
                data_valid          <= 1'b1;
            end
        end
    end

endmodule

// File: doc/acl_spi_reader.md
# acl_spi_reader

Produces the packed `acl_data` word that the seven-segment accelerometer display consumes. The block acts as an SPI master to the on-board ADXL362: after reset it writes the measurement-mode configuration, then periodically burst-reads the 8-bit X/Y/Z data registers. Each sample is converted to sign + 4-bit magnitude per axis, and the block publishes the word with a one-cycle valid strobe.

## Interface
Parameters:
- `CLK_DIV`, default 25: system cycles per SCLK half-period (2 MHz SCLK at 100 MHz); minimum 2.
- `SAMPLE_PERIOD`, default 10_000_000: cycles between read-transaction starts (100 ms).
- `STARTUP_WAIT`, default 1_000_000: cycles after reset before the config write (10 ms).
- `CS_GAP`, default 50: minimum cycles `cs_n` stays high between transactions.

Ports:
- `CLK100MHZ`, in, 1: system clock. The block has one clock.
- `reset`, in, 1: synchronous, active-high reset.
- `miso`, in, 1: SPI data from the ADXL362.
- `sclk`, out, 1: SPI clock, mode 0.
- `mosi`, out, 1: SPI data to the ADXL362.
- `cs_n`, out, 1: SPI chip select, active low.
- `acl_data`, out, 15: `{x_sign, x_mag[3:0], y_sign, y_mag[3:0], z_sign, z_mag[3:0]}`.
- `data_valid`, out, 1: one-cycle pulse when `acl_data` updates.

## Operation
- **Reset values:** `sclk`=0, `mosi`=0, `cs_n`=1, `acl_data`=0, `data_valid`=0. State is STARTUP and all counters are 0.
- **States:**
  - STARTUP: wait `STARTUP_WAIT` cycles, then go to CFG.
  - CFG: a 3-byte frame `0x0A, 0x2D, 0x02` (write POWER_CTL = measure). Then go to GAP.
  - GAP: hold `cs_n` high for `CS_GAP` cycles, then go to WAIT.
  - WAIT: wait until the sample timer expires, then go to READ.
  - READ: a 5-byte frame `0x0B, 0x08, dummy, dummy, dummy`. The three received bytes are X, Y and Z. Then go to LATCH.
  - LATCH: one cycle; update `acl_data` and pulse `data_valid`. Then go to GAP.
- **Dummy bytes:** `mosi` transmits 0x00 for the dummy bytes.
- **Sample timer:** free-runs from the end of CFG. It reloads every `SAMPLE_PERIOD` cycles.
  - A READ starts at the first expiry at which the block is in WAIT.
  - An expiry that occurs while the block is outside WAIT is remembered as a pending flag (depth 1). Expiries are never queued beyond one.
- **Axis conversion**, for an 8-bit two's-complement value v:
  - sign = v[7].
  - abs = |v|, computed 8 bits wide, so −128 gives 128.
  - mag = 15 when abs ≥ 128, otherwise abs[6:3].
  - Example: +1 g (0x40) gives mag 8.
- **Publishing:** `acl_data` changes only in LATCH, all three axes in the same cycle. There is no partial update.
- **Reset mid-transaction:** on the next cycle `cs_n`=1 and `sclk`=0. Sequencing restarts from STARTUP, including the config write. `acl_data` clears to 0.

## Timing
- **SPI mode 0 (CPOL=0, CPHA=0), bits MSB first.**
  - `cs_n` falls. The first `mosi` bit is valid in the same cycle.
  - The first SCLK rise comes `CLK_DIV` cycles after `cs_n` falls.
  - `miso` is sampled on the system cycle in which `sclk` rises.
  - `mosi` changes on the cycle in which `sclk` falls.
  - `sclk` rises `CLK_DIV` cycles after each falling edge.
- **End of frame:** after the final falling edge `sclk` stays low. `cs_n` rises `CLK_DIV` cycles later.
- **Bytes within a frame:** back-to-back, with no extra idle between them.
- **Frame lengths:**
  - CFG: 24 SCLK periods, 48·`CLK_DIV` + `CLK_DIV` cycles with `cs_n` low.
  - READ: 40 SCLK periods, 81·`CLK_DIV` cycles with `cs_n` low.
- **Latency:** `data_valid` is asserted exactly 1 cycle after `cs_n` rises at the end of READ. `acl_data` holds the new value from that same cycle.
- **Back-to-back frames:** two frames are never less than `CS_GAP` cycles apart.

## Structure
- **Shared package `acl_pkg`:**
  - ADXL362 opcodes: WRITE 0x0A, READ 0x0B.
  - Register addresses: POWER_CTL 0x2D, XDATA 0x08.
  - Value MEASURE 0x02.
  - State enum.
  - `acl_data` field bit positions: x 14:10, y 9:5, z 4:0.
- **Sub-module `spi_byte_xfer`:**
  - Transfers one byte.
  - Ports: start, `tx_byte`, `rx_byte`, done, `sclk`, `mosi`, `miso`.
  - Parameter: `CLK_DIV`.
- **Top level:** the sequencer FSM, byte counter, sample timer and conversion logic. It owns `cs_n`.

## Test plan
- **Reset values:** assert `reset` for 5 cycles with `STARTUP_WAIT`=100. Outputs hold their reset values. The first `cs_n` fall occurs 100 cycles after `reset` deasserts.
- **Config frame:** use `CLK_DIV`=4. The SPI monitor captures bytes 0x0A, 0x2D, 0x02 with mode-0 edges. `cs_n` stays low for 196 cycles.
- **Normal read:** the slave model returns X=0x40, Y=0xC0, Z=0x00. Result: `acl_data`=15'b0_1000_1_1000_0_0000, and `data_valid` pulses once, 1 cycle after `cs_n` rises.
- **Saturation and sign:** X=0x80 gives x field 1_1111. Y=0x7F gives 0_1111. Z=0xFF gives 1_0000.
- **Reset mid-READ:** assert `reset` during byte 3. Next cycle `cs_n`=1, `sclk`=0, `acl_data`=0. After `STARTUP_WAIT` the config frame is re-sent.
- **Periodic sampling:** use `SAMPLE_PERIOD`=2000. Consecutive READ `cs_n` falls are exactly 2000 cycles apart. No gap is shorter than `CS_GAP`.
